// File: rtl/spectrum_event_counter_pkg.sv
// Shared defaults and FSM state type for the spectrogram acquisition front end.
package spectro_pkg;

  localparam int DEFAULT_N_CH   = 14;
  localparam int DEFAULT_CNT_W  = 4;
  localparam int DEFAULT_THRESH = 8;
  localparam int DEFAULT_SLOT_W = 8;

  typedef enum logic {
    ST_ALIGN,
    ST_COUNT
  } state_t;

endpackage

// File: rtl/sync_rise_detector.sv
// Two-flop synchronizer for one asynchronous line, plus a delay flop that
// turns each low-to-high transition into a single-cycle rise pulse.
module sync_rise_detector (
  input  logic clk,
  input  logic srst,
  input  logic async_in,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic delay_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg  <= 1'b0;
      sync_reg  <= 1'b0;
      delay_reg <= 1'b0;
    end else begin
      meta_reg  <= async_in;
      sync_reg  <= meta_reg;
      delay_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~delay_reg;

endmodule

// File: rtl/spectrum_event_counter.sv
// Counts filterbank event rises per channel over each RTC window and offers
// one count frame per window through a single-entry valid/ready buffer.
module spectrum_event_counter
  import spectro_pkg::*;
#(
  parameter int N_CH   = DEFAULT_N_CH,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int THRESH = DEFAULT_THRESH,
  parameter int SLOT_W = DEFAULT_SLOT_W
) (
  input  logic                    input_acquisition_clk,
  input  logic                    reset,
  input  logic [6:0]              ch1,
  input  logic [6:0]              ch2,
  input  logic                    RTC_clk,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [N_CH*CNT_W-1:0]   frame_counts,
  output logic [SLOT_W-1:0]       frame_slot,
  output logic                    signal_detected,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]        ch_all;
  logic [N_CH-1:0]        ch_rise;
  logic [N_CH-1:0]        hit;
  logic [N_CH*CNT_W-1:0]  cnt_snapshot;
  logic                   rtc_rise;
  logic                   window_end;
  logic                   load_frame;
  state_t                 state_reg;
  state_t                 state_next;

  logic                   frame_valid_reg;
  logic [N_CH*CNT_W-1:0]  frame_counts_reg;
  logic [SLOT_W-1:0]      frame_slot_reg;
  logic                   signal_detected_reg;
  logic                   overrun_reg;
  logic [SLOT_W-1:0]      slot_cnt_reg;

  assign ch_all = {ch2, ch1};

  sync_rise_detector u_rtc_sync (
    .clk      (input_acquisition_clk),
    .srst     (reset),
    .async_in (RTC_clk),
    .rise     (rtc_rise)
  );

  // Per-channel synchronizer and saturating counter; the snapshot includes a
  // rise arriving on the window-end cycle so it lands in the closing frame.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_plus;

      sync_rise_detector u_sync (
        .clk      (input_acquisition_clk),
        .srst     (reset),
        .async_in (ch_all[gi]),
        .rise     (ch_rise[gi])
      );

      assign cnt_plus = (ch_rise[gi] && (cnt_reg != CNT_MAX)) ? cnt_reg + CNT_W'(1) : cnt_reg;
      assign cnt_snapshot[gi*CNT_W +: CNT_W] = cnt_plus;
      assign hit[gi] = (int'(cnt_plus) >= THRESH);

      always_ff @(posedge input_acquisition_clk) begin
        if (reset || (state_reg != ST_COUNT) || window_end) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_plus;
        end
      end
    end
  endgenerate

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      state_reg <= ST_ALIGN;
    end else begin
      state_reg <= state_next;
    end
  end

  // ALIGN waits for the first RTC tick so the first frame spans a full window.
  always_comb begin
    state_next = state_reg;
    window_end = 1'b0;
    case (state_reg)
      ST_ALIGN: if (rtc_rise) state_next = ST_COUNT;
      ST_COUNT: window_end = rtc_rise;
      default:  state_next = ST_ALIGN;
    endcase
  end

  assign load_frame = window_end && (!frame_valid_reg || frame_ready);

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      frame_valid_reg     <= 1'b0;
      frame_counts_reg    <= '0;
      frame_slot_reg      <= '0;
      signal_detected_reg <= 1'b0;
      overrun_reg         <= 1'b0;
      slot_cnt_reg        <= '0;
    end else begin
      if (load_frame) begin
        frame_valid_reg     <= 1'b1;
        frame_counts_reg    <= cnt_snapshot;
        frame_slot_reg      <= slot_cnt_reg;
        signal_detected_reg <= |hit;
      end else if (frame_valid_reg && frame_ready) begin
        frame_valid_reg <= 1'b0;
      end
      if (window_end && !load_frame) begin
        overrun_reg <= 1'b1;
      end
      if (window_end) begin
        slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
      end
    end
  end

  assign frame_valid     = frame_valid_reg;
  assign frame_counts    = frame_counts_reg;
  assign frame_slot      = frame_slot_reg;
  assign signal_detected = signal_detected_reg;
  assign overrun         = overrun_reg;

endmodule
